sattn_rocc_frontend: RTL and testbench
======================================

// Module: sattn_rocc_frontend
// PURPOSE
//  RoCC-side command front end for the sparse-attention accelerator. Accepts custom-instruction
//  commands, queues them, and turns each into MMIO write/read sequences on the accelerator
//  register file. Waits for completion and returns a checksum/status response to the core.
//  Sits directly upstream of the accelerator; it is the sole MMIO master on that interface.
// PARAMETERS
//  CMD_DEPTH      4      command FIFO entries (power of two, >=2)
//  TIMEOUT_CYCLES 65535  max cycles in WAIT_DONE before timeout abort (0 = no timeout)
// PORTS
//  clk         in   1   clock
//  rstn        in   1   asynchronous active-low reset
//  cmd_valid   in   1   RoCC command valid
//  cmd_ready   out  1   FIFO not full
//  cmd_funct   in   7   operation (see BEHAVIOUR)
//  cmd_rs1     in   64  operand 1
//  cmd_rs2     in   64  operand 2
//  cmd_rd      in   5   destination register tag
//  cmd_xd      in   1   response required
//  resp_valid  out  1   response valid
//  resp_ready  in   1   core accepts response
//  resp_rd     out  5   echoed cmd_rd
//  resp_data   out  64  response payload
//  mmio_wen    out  1   MMIO write strobe
//  mmio_ren    out  1   MMIO read strobe
//  mmio_addr   out  16  MMIO byte offset
//  mmio_wdata  out  64  MMIO write data
//  mmio_rdata  in   64  MMIO read data (combinational from mmio_addr, same cycle)
//  accel_done  in   1   accelerator one-cycle done pulse
//  fe_busy     out  1   FIFO non-empty or FSM not IDLE
//  err_timeout out  1   sticky; set on timeout, cleared when next ISSUE is popped
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; FIFO empty; FSM IDLE; counters 0. Reset mid-op aborts
//   the sequence immediately; no response emitted for in-flight command.
//  FIFO: push on cmd_valid&cmd_ready; simultaneous push+pop when full is NOT allowed (ready=0 when full).
//  Funct: 0 CFG  write rs2 to offset rs1[15:0]; 1 ISSUE write rs1[7:0] to 0x60, wait done;
//   2 READ read offset rs1[15:0]; 3 IDX write rs1[15:0]->0x70 then rs2[15:0]->0x78; 4 PERF; other: NOP.
//  FSM: IDLE -pop-> {CFG_WR | IDX_WR0->IDX_WR1->IDX_GAP | ISSUE_WR->WAIT_DONE->SETTLE->RD_RES | RD}
//   -> RESP (if xd) -> IDLE. Each *_WR/RD state is exactly one cycle with strobe high.
//  IDX_GAP: one mandatory cycle with mmio_wen=0 after the 0x78 write (commit strobe must deassert).
//  WAIT_DONE: exits on accel_done; SETTLE one idle cycle (checksum latches after done);
//   RD_RES reads 0x68 (op 0x14), 0x80 (op 0x15), 0x88 (op 0x16), else 0x60 status.
//  Timeout: counter hits TIMEOUT_CYCLES in WAIT_DONE -> set err_timeout, resp_data=64'hFFFF_FFFF_FFFF_FFFF.
//  ISSUE with rs1[7:0]==0 (NOP): write 0x60, skip wait, resp_data=0.
//  RESP: resp_valid held until resp_ready; data/rd stable while stalled. CFG/IDX/NOP with xd: data=0.
//  accel_done outside WAIT_DONE ignored. Min ISSUE latency pop->resp_valid = 5 cycles + accel latency.
// CONFIGURATION
//  SATTN_FE_PERF_EN defined: 32-bit counter of cycles in WAIT_DONE accumulated over all ISSUEs,
//   saturating; funct 4 returns {32'd0,count} and clears it. Not defined: no counter, funct 4 returns 0.
// STRUCTURE
//  sattn_pkg: accelerator opcode enum (0x10-0x16), MMIO offsets (0x00-0x88), funct enum, FSM state enum.
//  Sub-module sattn_cmd_fifo: CMD_DEPTH x {funct,rs1,rs2,rd,xd}, push/pop/full/empty, ptr wrap.
// TESTING
//  CFG funct0 rs1=0x30 rs2=8 -> one-cycle mmio_wen, addr 0x30, wdata 8; no resp when xd=0.
//  IDX rs1=5 rs2=0x1234 -> writes 0x70=5, 0x78=0x1234, then one mmio_wen=0 cycle before next cmd.
//  ISSUE 0x14 xd=1, done after 20 cycles -> read 0x68 one cycle after SETTLE, resp_data=mmio_rdata.
//  ISSUE 0x15, no done, TIMEOUT_CYCLES=100 -> resp all-ones, err_timeout=1; next ISSUE clears it.
//  Push 5 cmds while resp_ready=0 -> cmd_ready drops after 4 (plus in-flight); resp data stable.
//  Assert rstn low in WAIT_DONE -> outputs reset, FIFO empty, no resp after release.

Source files
------------

// File: rtl/sattn_pkg.sv
// Shared types for the sparse-attention RoCC front end: accelerator opcodes, MMIO map,
// RoCC funct codes, command record and front-end FSM states.
package sattn_pkg;

  typedef enum logic [7:0] {
    OP_CLEAR       = 8'h10,
    OP_LOAD_Q      = 8'h11,
    OP_LOAD_KV     = 8'h12,
    OP_SCORE       = 8'h13,
    OP_CHKSUM_OUT  = 8'h14,
    OP_CHKSUM_ATTN = 8'h15,
    OP_CHKSUM_IDX  = 8'h16
  } accel_op_e;

  localparam logic [15:0] MMIO_OPCODE    = 16'h0060;
  localparam logic [15:0] MMIO_STATUS    = 16'h0060;
  localparam logic [15:0] MMIO_CHK_OUT   = 16'h0068;
  localparam logic [15:0] MMIO_IDX_LO    = 16'h0070;
  localparam logic [15:0] MMIO_IDX_HI    = 16'h0078;
  localparam logic [15:0] MMIO_CHK_ATTN  = 16'h0080;
  localparam logic [15:0] MMIO_CHK_IDX   = 16'h0088;

  typedef enum logic [6:0] {
    F_CFG   = 7'd0,
    F_ISSUE = 7'd1,
    F_READ  = 7'd2,
    F_IDX   = 7'd3,
    F_PERF  = 7'd4
  } funct_e;

  typedef struct packed {
    logic [6:0]  funct;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [4:0]  rd;
    logic        xd;
  } cmd_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_WR,
    S_IDX_WR0,
    S_IDX_WR1,
    S_IDX_GAP,
    S_ISSUE_WR,
    S_WAIT_DONE,
    S_SETTLE,
    S_RD_RES,
    S_RD,
    S_RESP
  } state_e;

  // Checksum-producing opcodes have their own result register; everything else reports status.
  function automatic logic [15:0] result_offset(input logic [7:0] op);
    case (op)
      OP_CHKSUM_OUT:  return MMIO_CHK_OUT;
      OP_CHKSUM_ATTN: return MMIO_CHK_ATTN;
      OP_CHKSUM_IDX:  return MMIO_CHK_IDX;
      default:        return MMIO_STATUS;
    endcase
  endfunction

endpackage

// File: rtl/sattn_cmd_fifo.sv
// Command queue between the RoCC command port and the front-end sequencer.
// DEPTH must be a power of two; pointers carry one extra wrap bit for full/empty.
module sattn_cmd_fifo
  import sattn_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  cmd_t        mem_q [DEPTH];
  cmd_t        mem_d [DEPTH];
  logic        do_push, do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = push_data;
      wptr_d = wptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sattn_rocc_frontend.sv
// RoCC command front end: queues commands and sequences MMIO traffic to the accelerator.
// Optional SATTN_FE_PERF_EN adds a saturating WAIT_DONE cycle counter read back by funct 4.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for a queued command; pops it when present
// S_CFG_WR    | one-cycle write of rs2 to offset rs1[15:0]
// S_IDX_WR0   | one-cycle write of rs1[15:0] to the index-low register
// S_IDX_WR1   | one-cycle write of rs2[15:0] to the index-high (commit) register
// S_IDX_GAP   | forced idle cycle so the commit strobe deasserts
// S_ISSUE_WR  | one-cycle opcode write; opcode 0 skips the wait
// S_WAIT_DONE | waiting for accel_done, bounded by the timeout down-counter
// S_SETTLE    | idle cycle while the accelerator latches its checksum
// S_RD_RES    | one-cycle read of the opcode's result register
// S_RD        | one-cycle read of offset rs1[15:0]
// S_RESP      | response held until resp_ready
module sattn_rocc_frontend
  import sattn_pkg::*;
#(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_funct,
  input  logic [63:0] cmd_rs1,
  input  logic [63:0] cmd_rs2,
  input  logic [4:0]  cmd_rd,
  input  logic        cmd_xd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd,
  output logic [63:0] resp_data,
  output logic        mmio_wen,
  output logic        mmio_ren,
  output logic [15:0] mmio_addr,
  output logic [63:0] mmio_wdata,
  input  logic [63:0] mmio_rdata,
  input  logic        accel_done,
  output logic        fe_busy,
  output logic        err_timeout
);

  state_e      state_q, state_d;
  cmd_t        cur_q, cur_d;
  cmd_t        head, push_data;
  logic        full, empty, pop;
  logic [63:0] resp_data_q, resp_data_d;
  logic        err_q, err_d;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] perf_val;
  logic        unused_cur;

  assign push_data = '{funct: cmd_funct, rs1: cmd_rs1, rs2: cmd_rs2, rd: cmd_rd, xd: cmd_xd};
  assign pop       = (state_q == S_IDLE) && !empty;

  sattn_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (cmd_valid),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  function automatic state_e finish_st(input logic xd);
    return xd ? S_RESP : S_IDLE;
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;
    tmr_d       = tmr_q;
    mmio_wen    = 1'b0;
    mmio_ren    = 1'b0;
    mmio_addr   = '0;
    mmio_wdata  = '0;
    resp_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          cur_d       = head;
          resp_data_d = '0;
          case (head.funct)
            F_CFG:   state_d = S_CFG_WR;
            F_ISSUE: begin
              state_d = S_ISSUE_WR;
              err_d   = 1'b0;
            end
            F_READ:  state_d = S_RD;
            F_IDX:   state_d = S_IDX_WR0;
            F_PERF:  begin
              resp_data_d = {32'd0, perf_val};
              state_d     = finish_st(head.xd);
            end
            default: state_d = finish_st(head.xd);
          endcase
        end
      end
      S_CFG_WR: begin
        mmio_wen   = 1'b1;
        mmio_addr  = cur_q.rs1[15:0];
        mmio_wdata = cur_q.rs2;
        state_d    = finish_st(cur_q.xd);
      end
      S_IDX_WR0: begin
        mmio_wen   = 1'b1;
        mmio_addr  = MMIO_IDX_LO;
        mmio_wdata = {48'd0, cur_q.rs1[15:0]};
        state_d    = S_IDX_WR1;
      end
      S_IDX_WR1: begin
        mmio_wen   = 1'b1;
        mmio_addr  = MMIO_IDX_HI;
        mmio_wdata = {48'd0, cur_q.rs2[15:0]};
        state_d    = S_IDX_GAP;
      end
      S_IDX_GAP: state_d = finish_st(cur_q.xd);
      S_ISSUE_WR: begin
        mmio_wen   = 1'b1;
        mmio_addr  = MMIO_OPCODE;
        mmio_wdata = {56'd0, cur_q.rs1[7:0]};
        tmr_d      = TIMEOUT_CYCLES;
        state_d    = (cur_q.rs1[7:0] == 8'd0) ? finish_st(cur_q.xd) : S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // Done wins over a coincident terminal count.
        if (accel_done) begin
          state_d = S_SETTLE;
        end else if ((TIMEOUT_CYCLES != 0) && (tmr_q == 32'd1)) begin
          err_d       = 1'b1;
          resp_data_d = '1;
          state_d     = finish_st(cur_q.xd);
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      S_SETTLE: state_d = S_RD_RES;
      S_RD_RES: begin
        mmio_ren    = 1'b1;
        mmio_addr   = result_offset(cur_q.rs1[7:0]);
        resp_data_d = mmio_rdata;
        state_d     = finish_st(cur_q.xd);
      end
      S_RD: begin
        mmio_ren    = 1'b1;
        mmio_addr   = cur_q.rs1[15:0];
        resp_data_d = mmio_rdata;
        state_d     = finish_st(cur_q.xd);
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
      tmr_q       <= tmr_d;
    end
  end

`ifdef SATTN_FE_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (pop && (head.funct == F_PERF)) begin
      perf_d = '0;
    end else if ((state_q == S_WAIT_DONE) && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_val = perf_q;
`else
  assign perf_val = '0;
`endif

  // Funct and the upper operand bits are carried in the command record but never consumed.
  assign unused_cur = ^{cur_q.funct, cur_q.rs1[63:16]};

  assign cmd_ready   = !full;
  assign resp_rd     = cur_q.rd;
  assign resp_data   = resp_data_q;
  assign err_timeout = err_q;
  assign fe_busy     = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_sattn_rocc_frontend.sv
// Self-checking bench for sattn_rocc_frontend: table-driven commands with an MMIO/response
// scoreboard, plus hand sequences for latency, timeout, backpressure and mid-op reset.
module tb_sattn_rocc_frontend;

  localparam int unsigned TMO = 100;
  localparam int EV_WR = 0, EV_RD = 1, EV_RESP = 2;
  localparam int NV = 13;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_funct = '0;
  logic [63:0] cmd_rs1 = '0;
  logic [63:0] cmd_rs2 = '0;
  logic [4:0]  cmd_rd = '0;
  logic        cmd_xd = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [4:0]  resp_rd;
  logic [63:0] resp_data;
  logic        mmio_wen, mmio_ren;
  logic [15:0] mmio_addr;
  logic [63:0] mmio_wdata;
  logic [63:0] mmio_rdata;
  logic        accel_done;
  logic        done_pulse = 1'b0;
  logic        stray_pulse = 1'b0;
  logic        fe_busy, err_timeout;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int issue_cyc = 0, rd_cyc = 0, resp_rise_cyc = 0;
  int done_dly = 0;
  int perf_acc = 0;
  bit prev78 = 1'b0;
  bit resp_prev = 1'b0;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [63:0] data;
    logic [4:0]  rd;
  } ev_t;

  typedef struct {
    logic [6:0]  funct;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [4:0]  rd;
    logic        xd;
    int          dly;
    logic [63:0] exp;
  } vec_t;

  ev_t  sb[$];
  vec_t vt[NV];

  function automatic logic [63:0] rdm(input logic [15:0] a);
    return 64'hD00D_0000_0000_0000 | {48'd0, a};
  endfunction

  function automatic logic [15:0] res_off(input logic [7:0] op);
    case (op)
      8'h14:   return 16'h0068;
      8'h15:   return 16'h0080;
      8'h16:   return 16'h0088;
      default: return 16'h0060;
    endcase
  endfunction

  assign mmio_rdata = rdm(mmio_addr);
  assign accel_done = done_pulse | stray_pulse;

  sattn_rocc_frontend #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_funct   (cmd_funct),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_rd      (cmd_rd),
    .cmd_xd      (cmd_xd),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rd     (resp_rd),
    .resp_data   (resp_data),
    .mmio_wen    (mmio_wen),
    .mmio_ren    (mmio_ren),
    .mmio_addr   (mmio_addr),
    .mmio_wdata  (mmio_wdata),
    .mmio_rdata  (mmio_rdata),
    .accel_done  (accel_done),
    .fe_busy     (fe_busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [15:0] addr, input logic [63:0] data,
                         input logic [4:0] rd);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic check_event(input int kind, input logic [15:0] addr, input logic [63:0] data,
                             input logic [4:0] rd);
    ev_t e;
    vec_cnt++;
    if (sb.size() == 0) begin
      err_cnt++;
      $display("FAIL sb_unexpected: got kind=%0d addr=%h data=%h rd=%0d, expected no event",
               kind, addr, data, rd);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.addr !== addr || e.data !== data || e.rd !== rd) begin
        err_cnt++;
        $display("FAIL sb_event: got kind=%0d addr=%h data=%h rd=%0d, expected kind=%0d addr=%h data=%h rd=%0d",
                 kind, addr, data, rd, e.kind, e.addr, e.data, e.rd);
      end
    end
  endtask

  // Monitor: every strobe and every accepted response must match the scoreboard head.
  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (prev78) begin
        vec_cnt++;
        if (mmio_wen) begin
          err_cnt++;
          $display("FAIL idx_gap: got mmio_wen=1 after 0x78 write, expected 0");
        end
      end
      prev78 = mmio_wen && (mmio_addr == 16'h0078);
      if (mmio_wen) begin
        if (mmio_addr == 16'h0060) issue_cyc = cyc;
        check_event(EV_WR, mmio_addr, mmio_wdata, 5'd0);
      end
      if (mmio_ren) begin
        rd_cyc = cyc;
        check_event(EV_RD, mmio_addr, mmio_rdata, 5'd0);
      end
      if (resp_valid && !resp_prev) resp_rise_cyc = cyc;
      resp_prev = resp_valid;
      if (resp_valid && resp_ready) check_event(EV_RESP, 16'h0000, resp_data, resp_rd);
    end else begin
      prev78    = 1'b0;
      resp_prev = 1'b0;
    end
  end

  // Accelerator model: done pulse dly cycles after a non-NOP opcode write (dly 0 = never).
  always @(negedge clk) begin
    if (rstn && mmio_wen && mmio_addr == 16'h0060 && mmio_wdata[7:0] != 8'd0 && done_dly > 0) begin
      repeat (done_dly) @(negedge clk);
      done_pulse = 1'b1;
      @(negedge clk);
      done_pulse = 1'b0;
    end
  end

  task automatic expect_cmd(input vec_t v, input logic [63:0] exp);
    case (v.funct)
      7'd0: push_ev(EV_WR, v.rs1[15:0], v.rs2, 5'd0);
      7'd1: begin
        push_ev(EV_WR, 16'h0060, {56'd0, v.rs1[7:0]}, 5'd0);
        if (v.rs1[7:0] != 8'd0 && v.dly > 0)
          push_ev(EV_RD, res_off(v.rs1[7:0]), rdm(res_off(v.rs1[7:0])), 5'd0);
      end
      7'd2: push_ev(EV_RD, v.rs1[15:0], rdm(v.rs1[15:0]), 5'd0);
      7'd3: begin
        push_ev(EV_WR, 16'h0070, {48'd0, v.rs1[15:0]}, 5'd0);
        push_ev(EV_WR, 16'h0078, {48'd0, v.rs2[15:0]}, 5'd0);
      end
      default: ;
    endcase
    if (v.xd) push_ev(EV_RESP, 16'h0000, exp, v.rd);
  endtask

  task automatic send(input vec_t v);
    int n;
    done_dly = v.dly;
    @(negedge clk);
    cmd_funct = v.funct; cmd_rs1 = v.rs1; cmd_rs2 = v.rs2;
    cmd_rd = v.rd; cmd_xd = v.xd; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL send_ready: got cmd_ready=%0b expected 1 within 300 cycles", cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string what);
    int n;
    n = 0;
    @(negedge clk);
    while ((fe_busy || resp_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({what, "_idle_bound"}, 64'(n >= 1000), 64'd0);
    chk({what, "_sb_drained"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic run_vec(input vec_t v, input string what);
    logic [63:0] exp;
    exp = v.exp;
    if (v.funct == 7'd1 && v.rs1[7:0] != 8'd0) perf_acc += (v.dly > 0) ? v.dly : int'(TMO);
    if (v.funct == 7'd4) begin
`ifdef SATTN_FE_PERF_EN
      exp = {32'd0, 32'(perf_acc)};
`else
      exp = 64'd0;
`endif
      perf_acc = 0;
    end
    expect_cmd(v, exp);
    send(v);
    wait_idle(what);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   old, n;

    vt[0]  = '{7'd0, 64'h30,          64'd8,                  5'd0, 1'b0, 0,  64'd0};
    vt[1]  = '{7'd0, 64'h1_0040,      64'hDEAD_BEEF_0123_4567, 5'd3, 1'b1, 0,  64'd0};
    vt[2]  = '{7'd3, 64'h5,           64'h1234,               5'd0, 1'b0, 0,  64'd0};
    vt[3]  = '{7'd3, 64'hFFFF_ABCD,   64'h9_8765,             5'd7, 1'b1, 0,  64'd0};
    vt[4]  = '{7'd2, 64'h20,          64'd0,                  5'd9, 1'b1, 0,  64'hD00D_0000_0000_0020};
    vt[5]  = '{7'd2, 64'h88,          64'd0,                  5'd0, 1'b0, 0,  64'd0};
    vt[6]  = '{7'd1, 64'h14,          64'd0,                  5'd1, 1'b1, 20, 64'hD00D_0000_0000_0068};
    vt[7]  = '{7'd1, 64'h15,          64'd0,                  5'd2, 1'b1, 1,  64'hD00D_0000_0000_0080};
    vt[8]  = '{7'd1, 64'h16,          64'd0,                  5'd3, 1'b1, 3,  64'hD00D_0000_0000_0088};
    vt[9]  = '{7'd1, 64'h12,          64'd0,                  5'd8, 1'b1, 2,  64'hD00D_0000_0000_0060};
    vt[10] = '{7'd1, 64'h100,         64'd0,                  5'd4, 1'b1, 0,  64'd0};
    vt[11] = '{7'd9, 64'h55,          64'h66,                 5'd2, 1'b1, 0,  64'd0};
    vt[12] = '{7'd4, 64'd0,           64'd0,                  5'd31, 1'b1, 0, 64'd0};

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready",  64'(cmd_ready),   64'd1);
    chk("rst_resp_valid", 64'(resp_valid),  64'd0);
    chk("rst_mmio_wen",   64'(mmio_wen),    64'd0);
    chk("rst_mmio_ren",   64'(mmio_ren),    64'd0);
    chk("rst_mmio_addr",  64'(mmio_addr),   64'd0);
    chk("rst_fe_busy",    64'(fe_busy),     64'd0);
    chk("rst_err",        64'(err_timeout), 64'd0);
    chk("rst_resp_data",  resp_data,        64'd0);
    chk("rst_resp_rd",    64'(resp_rd),     64'd0);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Latency: done 20 cycles after the opcode write, then the minimum-latency case.
    run_vec('{7'd1, 64'h14, 64'd0, 5'd1, 1'b1, 20, 64'hD00D_0000_0000_0068}, "lat20");
    chk("lat20_read_cycle", 64'(rd_cyc - issue_cyc),        64'd22);
    chk("lat20_resp_cycle", 64'(resp_rise_cyc - issue_cyc), 64'd23);
    run_vec('{7'd1, 64'h15, 64'd0, 5'd2, 1'b1, 1, 64'hD00D_0000_0000_0080}, "lat1");
    chk("lat1_resp_cycle",  64'(resp_rise_cyc - issue_cyc), 64'd4);

    // IDX immediately followed by CFG: commit strobe gap is checked by the monitor.
    v = '{7'd3, 64'h5, 64'h1234, 5'd0, 1'b0, 0, 64'd0};
    expect_cmd(v, 64'd0);
    send(v);
    v = '{7'd0, 64'h30, 64'd8, 5'd0, 1'b0, 0, 64'd0};
    expect_cmd(v, 64'd0);
    send(v);
    wait_idle("idx_cfg");

    // Timeout, sticky error, then cleared by the next ISSUE pop.
    run_vec('{7'd1, 64'h15, 64'd0, 5'd6, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF}, "tmo");
    chk("tmo_err_set",     64'(err_timeout),                64'd1);
    chk("tmo_resp_cycle",  64'(resp_rise_cyc - issue_cyc),  64'(TMO + 1));
    run_vec('{7'd4, 64'd0, 64'd0, 5'd12, 1'b1, 0, 64'd0}, "perf2");
    chk("tmo_err_sticky",  64'(err_timeout),                64'd1);
    run_vec('{7'd1, 64'h14, 64'd0, 5'd0, 1'b0, 2, 64'd0}, "tmo_clear");
    chk("tmo_err_cleared", 64'(err_timeout),                64'd0);

    // Backpressure: five reads with responses stalled.
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = '{7'd2, 64'(16'h10 + i), 64'd0, 5'(10 + i), 1'b1, 0, rdm(16'(16'h10 + i))};
      expect_cmd(v, v.exp);
      send(v);
    end
    @(negedge clk);
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("bp_fe_busy",   64'(fe_busy),   64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_resp_data",  resp_data,       rdm(16'h0010));
      chk("bp_resp_rd",    64'(resp_rd),    64'd10);
    end
    resp_ready = 1'b1;
    wait_idle("bp");

    // Stray accel_done while idle must be ignored.
    @(negedge clk);
    stray_pulse = 1'b1;
    @(negedge clk);
    stray_pulse = 1'b0;
    repeat (5) @(negedge clk);
    chk("stray_fe_busy",    64'(fe_busy),    64'd0);
    chk("stray_resp_valid", 64'(resp_valid), 64'd0);

    // Reset while waiting for done: no response afterwards.
    old = issue_cyc;
    v = '{7'd1, 64'h13, 64'd0, 5'd5, 1'b1, 0, 64'd0};
    push_ev(EV_WR, 16'h0060, 64'h13, 5'd0);
    send(v);
    n = 0;
    while (issue_cyc == old && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_issue_seen", 64'(n >= 200), 64'd0);
    repeat (5) @(negedge clk);
    chk("rstmid_busy_before", 64'(fe_busy), 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("rstmid_resp_valid", 64'(resp_valid),  64'd0);
    chk("rstmid_fe_busy",    64'(fe_busy),     64'd0);
    chk("rstmid_cmd_ready",  64'(cmd_ready),   64'd1);
    chk("rstmid_mmio_wen",   64'(mmio_wen),    64'd0);
    chk("rstmid_resp_data",  resp_data,        64'd0);
    old = resp_rise_cyc;
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("rstmid_no_resp",    64'(resp_rise_cyc - old), 64'd0);
    chk("rstmid_idle",       64'(fe_busy),             64'd0);
    chk("rstmid_sb_empty",   64'(sb.size()),           64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
